// File: rtl/bram_log_reader_pkg.sv
// ----------------------------------------------------------------------------
// bram_log_pkg
//
// Shared definitions for the BRAM log drain engine and the logger that fills
// the log memory.
//   - Entry layout: one logged entry is 96 bits, stored as three consecutive
//     32-bit words (word 0 = timestamp, word 1 = AXI address,
//     word 2 = len in [7:0] and ID starting at bit 8).
//   - state_e: drain FSM states.
//   - log_entry_t: packed view of one entry, with word 0 in the LSBs.
//   - cap_entries(): log capacity, which is the depth rounded up to whole
//     1024-entry blocks.
// ----------------------------------------------------------------------------
package bram_log_pkg;

  localparam int unsigned ENTRY_BITW      = 96;
  localparam int unsigned WORD_BITW       = 32;
  localparam int unsigned WORDS_PER_ENTRY = 3;
  localparam int unsigned TS_LOW          = 0;
  localparam int unsigned ADDR_LOW        = 32;
  localparam int unsigned LEN_LOW         = 64;
  localparam int unsigned ID_LOW          = 72;

  // AXI address and len widths are fixed by the logger.
  localparam int unsigned AXI_ADDR_BITW   = 32;
  localparam int unsigned AXI_LEN_BITW    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_OUT,
    ST_CLEAR,
    ST_WAIT
  } state_e;

  // Word 0 occupies the least significant bits, so the packed struct can also
  // be sliced with the *_LOW offsets above.
  typedef struct packed {
    logic [WORD_BITW-1:0] word2;
    logic [WORD_BITW-1:0] word1;
    logic [WORD_BITW-1:0] word0;
  } log_entry_t;

  function automatic int unsigned cap_entries(input int unsigned num_entries);
    return 1024 * ((num_entries + 1023) / 1024);
  endfunction

endpackage

// File: rtl/bram_log_reader_if.sv
// ----------------------------------------------------------------------------
// BramPort
//
// Simple single-port BRAM access bundle. The read latency is one cycle: Rd_D
// carries the word addressed by Addr_S in the cycle after En_S was high.
//   Clk_C   master->slave  port clock
//   Rst_R   master->slave  port reset, active high
//   En_S    master->slave  access enable
//   Addr_S  master->slave  byte address
//   WrEn_S  master->slave  byte write enables
//   Wr_D    master->slave  write data
//   Rd_D    slave->master  read data
// ----------------------------------------------------------------------------
interface BramPort #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                    Clk_C;
  logic                    Rst_R;
  logic                    En_S;
  logic [ADDR_WIDTH-1:0]   Addr_S;
  logic [DATA_WIDTH/8-1:0] WrEn_S;
  logic [DATA_WIDTH-1:0]   Wr_D;
  logic [DATA_WIDTH-1:0]   Rd_D;

  modport master (
    output Clk_C, Rst_R, En_S, Addr_S, WrEn_S, Wr_D,
    input  Rd_D
  );

  modport slave (
    input  Clk_C, Rst_R, En_S, Addr_S, WrEn_S, Wr_D,
    output Rd_D
  );

endinterface

// File: rtl/bram_log_reader.sv
// ----------------------------------------------------------------------------
// bram_log_reader
//
// Drains the AXI BRAM logger: reads each 96-bit entry as three 32-bit words,
// presents the unpacked fields on a valid/ready output, then pulses the
// logger's clear input and waits out its clearing sweep before accepting a
// new drain request.
//
// Ports:
//   Clk_CI         clock
//   Rst_RBI        asynchronous reset, active low
//   Start_SI       drain request, only looked at while idle
//   Full_SI        logger full flag (auto-drain trigger, see below)
//   Clear_SO       one-cycle clear pulse to the logger
//   Busy_SO        high whenever the engine is not idle
//   EntryValid_SO  entry fields are valid
//   EntryReady_SI  consumer accepts the entry
//   EntryTs_DO     timestamp field
//   EntryAddr_DO   AXI address field
//   EntryLen_DO    AXI len field
//   EntryId_DO     AXI ID field
//   EntryIdx_DO    index of the entry in the log
//   Bram_PM        read-only master port onto the logger memory
//
// Build option:
//   BRAM_LOG_READER_AUTO_DRAIN_EN  when defined, Full_SI high while idle
//                                  starts a drain just like Start_SI.
// ----------------------------------------------------------------------------
module bram_log_reader
  import bram_log_pkg::*;
#(
  parameter int unsigned AXI_ID_BITW     = 8,
  parameter int unsigned TIMESTAMP_BITW  = 32,
  parameter int unsigned NUM_LOG_ENTRIES = 16384,
  localparam int unsigned CAP            = cap_entries(NUM_LOG_ENTRIES),
  localparam int unsigned IDX_BITW       = $clog2(CAP)
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic                      Start_SI,
  input  logic                      Full_SI,
  output logic                      Clear_SO,
  output logic                      Busy_SO,
  output logic                      EntryValid_SO,
  input  logic                      EntryReady_SI,
  output logic [TIMESTAMP_BITW-1:0] EntryTs_DO,
  output logic [AXI_ADDR_BITW-1:0]  EntryAddr_DO,
  output logic [AXI_LEN_BITW-1:0]   EntryLen_DO,
  output logic [AXI_ID_BITW-1:0]    EntryId_DO,
  output logic [IDX_BITW-1:0]       EntryIdx_DO,
  BramPort.master                   Bram_PM
);

  // One extra bit so the same counter can run through the CAP+2 cycle wait.
  localparam int unsigned CNT_BITW = IDX_BITW + 1;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [CNT_BITW-1:0] idx_q, idx_d;
  log_entry_t          entry_q, entry_d;

  logic                start_req;
  logic                read_en;
  logic [31:0]         word_addr;
  logic                entry_all_zero;

`ifdef BRAM_LOG_READER_AUTO_DRAIN_EN
  assign start_req = Start_SI | Full_SI;
`else
  logic unused_full;
  assign unused_full = Full_SI;
  assign start_req   = Start_SI;
`endif

  // The upper bits of word 2 (and of word 0 for narrow timestamps) are
  // captured but carry no field.
  logic unused_entry_bits;
  assign unused_entry_bits = ^entry_q;

  // Read sub-steps: cnt 0..2 issue word reads, cnt 1..3 capture the word
  // read in the previous cycle.
  assign read_en   = (state_q == ST_READ) && (cnt_q < 3'd3);
  assign word_addr = 32'(idx_q) * 32'd3 + {29'd0, cnt_q};

  // Evaluated while word 2 is arriving; words 0 and 1 are already held.
  assign entry_all_zero = (entry_q.word0 == '0) && (entry_q.word1 == '0) &&
                          (Bram_PM.Rd_D == '0);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    entry_d = entry_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_READ;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      ST_READ: begin
        cnt_d = cnt_q + 3'd1;
        case (cnt_q)
          3'd1: entry_d.word0 = Bram_PM.Rd_D;
          3'd2: entry_d.word1 = Bram_PM.Rd_D;
          3'd3: begin
            entry_d.word2 = Bram_PM.Rd_D;
            // An all-zero entry past index 0 is memory the logger has
            // cleared, i.e. the end of the log. Spend one more cycle in
            // READ on it, then clear; otherwise present the entry.
            if (!((idx_q != '0) && entry_all_zero)) begin
              state_d = ST_OUT;
              cnt_d   = '0;
            end
          end
          3'd4: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end

      ST_OUT: begin
        if (EntryReady_SI) begin
          if (idx_q == CNT_BITW'(CAP - 1)) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_READ;
            cnt_d   = '0;
            idx_d   = idx_q + 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        state_d = ST_WAIT;
        idx_d   = '0;
      end

      ST_WAIT: begin
        // Covers the logger's clearing sweep; new requests are ignored.
        if (idx_q == CNT_BITW'(CAP + 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign Busy_SO       = (state_q != ST_IDLE);
  assign EntryValid_SO = (state_q == ST_OUT);
  assign Clear_SO      = (state_q == ST_CLEAR);

  assign EntryTs_DO    = entry_q[TS_LOW   +: TIMESTAMP_BITW];
  assign EntryAddr_DO  = entry_q[ADDR_LOW +: AXI_ADDR_BITW];
  assign EntryLen_DO   = entry_q[LEN_LOW  +: AXI_LEN_BITW];
  assign EntryId_DO    = entry_q[ID_LOW   +: AXI_ID_BITW];
  assign EntryIdx_DO   = idx_q[IDX_BITW-1:0];

  assign Bram_PM.Clk_C  = Clk_CI;
  assign Bram_PM.Rst_R  = ~Rst_RBI;
  assign Bram_PM.En_S   = read_en;
  assign Bram_PM.Addr_S = read_en ? {word_addr[29:0], 2'b00} : '0;
  assign Bram_PM.WrEn_S = '0;
  assign Bram_PM.Wr_D   = '0;

endmodule

// File: tb/tb_bram_log_reader.sv
// ----------------------------------------------------------------------------
// tb_bram_log_reader
//
// Drives bram_log_reader against a behavioural log memory. The expected entry
// stream is derived from the memory contents: entries in order from index 0,
// stopping before the first all-zero entry past index 0 or after the last
// entry of the log. A monitor compares every presented entry with that list.
// ----------------------------------------------------------------------------
module tb_bram_log_reader;
  import bram_log_pkg::*;

  localparam int ID_W   = 8;
  localparam int TS_W   = 32;
  localparam int NUM    = 1024;
  localparam int CAP    = 1024;
  localparam int IDX_W  = 10;
  localparam int BUDGET = 8000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             full;
  logic             clear;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [TS_W-1:0]  ts;
  logic [31:0]      eaddr;
  logic [7:0]       elen;
  logic [ID_W-1:0]  eid;
  logic [IDX_W-1:0] eidx;

  BramPort #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bram ();

  bram_log_reader #(
    .AXI_ID_BITW    (ID_W),
    .TIMESTAMP_BITW (TS_W),
    .NUM_LOG_ENTRIES(NUM)
  ) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .Start_SI     (start),
    .Full_SI      (full),
    .Clear_SO     (clear),
    .Busy_SO      (busy),
    .EntryValid_SO(valid),
    .EntryReady_SI(ready),
    .EntryTs_DO   (ts),
    .EntryAddr_DO (eaddr),
    .EntryLen_DO  (elen),
    .EntryId_DO   (eid),
    .EntryIdx_DO  (eidx),
    .Bram_PM      (bram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ts;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:3*CAP-1];

  int total       = 0;
  int bad         = 0;
  int hs_count    = 0;
  int clear_count = 0;
  bit mon_en      = 1'b0;
  bit pend_rd     = 1'b0;
  int pend_addr   = 0;

  // Log memory with one cycle read latency.
  always @(posedge clk) begin
    if (bram.En_S) bram.Rd_D <= mem[int'(bram.Addr_S[31:2])];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic build_model();
    exp_t        e;
    logic [31:0] w0, w1, w2;
    exp_q.delete();
    for (int i = 0; i < CAP; i++) begin
      w0 = mem[3*i];
      w1 = mem[3*i+1];
      w2 = mem[3*i+2];
      if (i > 0 && w0 == 0 && w1 == 0 && w2 == 0) break;
      e.ts   = w0;
      e.addr = w1;
      e.len  = w2[7:0];
      e.id   = w2[8 +: ID_W];
      e.idx  = i;
      exp_q.push_back(e);
    end
  endtask

  task automatic load_zero();
    for (int i = 0; i < 3*CAP; i++) mem[i] = 32'd0;
  endtask

  task automatic load_three();
    load_zero();
    mem[0] = 32'd5;  mem[1] = 32'h1000; mem[2] = 32'h0000_0103;
    mem[3] = 32'd9;  mem[4] = 32'h2000; mem[5] = 32'h0000_0200;
    // Junk in the unused upper bits of word 2 must not leak into the fields.
    mem[6] = 32'd12; mem[7] = 32'h3000; mem[8] = 32'hAB00_0307;
  endtask

  task automatic load_full();
    for (int e = 0; e < CAP; e++) begin
      mem[3*e]   = 32'h100 + 32'(e);
      mem[3*e+1] = 32'h8000_0000 + 32'(e) * 32'd16;
      mem[3*e+2] = {16'd0, 8'((e * 7) & 255), 8'(e & 255)};
    end
  endtask

  // Entry checker: every cycle an entry is presented it must match the head
  // of the expected list; a handshake retires it.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_rd = 1'b0;
    end else if (mon_en) begin
      if (pend_rd) begin
        chk("read_after_hs", {31'd0, bram.En_S, bram.Addr_S}, {32'd1, 32'(pend_addr)});
        pend_rd = 1'b0;
      end
      if (bram.En_S) chk("no_write", {28'd0, bram.WrEn_S, bram.Wr_D}, 64'd0);
      if (valid) begin
        chk("no_read_in_out", {63'd0, bram.En_S}, 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_entry: got idx %0d, want no entry", eidx);
        end else begin
          chk("entry_ts",   ts,    exp_q[0].ts);
          chk("entry_addr", eaddr, exp_q[0].addr);
          chk("entry_len",  elen,  exp_q[0].len);
          chk("entry_id",   eid,   exp_q[0].id);
          chk("entry_idx",  eidx,  exp_q[0].idx);
          if (ready) begin
            $display("entry idx=%0d ts=0x%0h addr=0x%0h len=%0d id=%0d",
                     eidx, ts, eaddr, elen, eid);
            if (exp_q[0].idx != CAP - 1) begin
              pend_rd   = 1'b1;
              pend_addr = (exp_q[0].idx + 1) * 12;
            end
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
      if (clear) begin
        clear_count++;
        $display("clear pulse, %0d entries outstanding", exp_q.size());
        chk("clear_after_last_entry", exp_q.size(), 64'd0);
      end
    end
  end

  // Runs one drain from request to idle. Cycle 0 is the request cycle.
  task automatic run_drain(input bit use_full, input int stall_idx, input int exp_n,
                           input int exp_clear_k, input int exp_last_addr);
    int first_valid_k = -1;
    int clear_k       = -1;
    int idle_k        = -1;
    int stall_left    = 10;
    int last_addr     = -1;
    int hs0           = hs_count;
    int cl0           = clear_count;
    bit done          = 1'b0;
    build_model();
    @(negedge clk);
    if (use_full) full = 1'b1;
    else          start = 1'b1;
    for (int k = 1; k <= BUDGET && !done; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      full  = 1'b0;
      if (k == 1) chk("first_read", {31'd0, bram.En_S, bram.Addr_S}, {32'd1, 32'd0});
      if (bram.En_S) last_addr = int'(bram.Addr_S);
      if (valid && first_valid_k < 0) first_valid_k = k;
      if (clear && clear_k < 0) clear_k = k;
      if (!busy) begin
        idle_k = k;
        done   = 1'b1;
      end
      if (valid && int'(eidx) == stall_idx && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = 1'b1;
      end
    end
    ready = 1'b1;
    chk("drain_finished",    done, 64'd1);
    chk("first_valid_cycle", first_valid_k, 64'd5);
    chk("entries_emitted",   hs_count - hs0, exp_n);
    chk("clear_pulses",      clear_count - cl0, 64'd1);
    chk("clear_cycle",       clear_k, exp_clear_k);
    chk("wait_length",       idle_k - clear_k, 64'd1027);
    chk("last_read_addr",    last_addr, exp_last_addr);
  endtask

  initial begin
    bit found;
    int busy_seen;
    rst_n = 1'b0;
    start = 1'b0;
    full  = 1'b0;
    ready = 1'b1;
    load_zero();

    #3;
    chk("rst_busy",     busy,  64'd0);
    chk("rst_valid",    valid, 64'd0);
    chk("rst_clear",    clear, 64'd0);
    chk("rst_en",       bram.En_S, 64'd0);
    chk("rst_ts",       ts,    64'd0);
    chk("rst_idx",      eidx,  64'd0);
    chk("rst_bram_rst", bram.Rst_R, 64'd1);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Pin the model on the three-entry log.
    load_three();
    build_model();
    chk("model_size",    exp_q.size(), 64'd3);
    chk("model_e1_addr", exp_q[1].addr, 64'h2000);
    chk("model_e2_ts",   exp_q[2].ts,  64'd12);
    chk("model_e2_len",  exp_q[2].len, 64'd7);
    chk("model_e2_id",   exp_q[2].id,  64'd3);

    // Three entries, terminal read of entry 3 at word address 11.
    run_drain(1'b0, -1, 3, 21, 44);

    // Consumer stalls 10 cycles on entry 1.
    load_three();
    run_drain(1'b0, 1, 3, 31, 44);

    // Empty log: entry 0 still emitted.
    load_zero();
    run_drain(1'b0, -1, 1, 11, 20);

    // Reset while reading entry 2.
    load_three();
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (valid && eidx == 1) found = 1'b1;
    end
    chk("reached_entry1", found, 64'd1);
    @(posedge clk);
    #1;
    chk("reading_entry2", {31'd0, bram.En_S, bram.Addr_S}, {32'd1, 32'd24});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  busy,  64'd0);
    chk("arst_valid", valid, 64'd0);
    chk("arst_clear", clear, 64'd0);
    chk("arst_en",    bram.En_S, 64'd0);
    chk("arst_baddr", bram.Addr_S, 64'd0);
    chk("arst_ts",    ts,    64'd0);
    chk("arst_addr",  eaddr, 64'd0);
    chk("arst_len",   elen,  64'd0);
    chk("arst_id",    eid,   64'd0);
    chk("arst_idx",   eidx,  64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("arst_no_clear", clear, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_drain(1'b0, -1, 3, 21, 44);

`ifdef BRAM_LOG_READER_AUTO_DRAIN_EN
    load_three();
    run_drain(1'b1, -1, 3, 21, 44);
`else
    busy_seen = 0;
    @(negedge clk);
    full = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen++;
    end
    full = 1'b0;
    chk("full_ignored", busy_seen, 64'd0);
`endif

    // Completely filled log.
    load_full();
    build_model();
    chk("model_full_size", exp_q.size(), 64'd1024);
    run_drain(1'b0, -1, 1024, 5121, 12284);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_log_reader.md
# bram_log_reader

Drain engine downstream of the AXI BRAM logger. It reads logged 96-bit entries over the logger's 32-bit BRAM slave port, unpacks each entry into timestamp, address, length and ID fields, and streams them out on a valid/ready interface. After the last entry it pulses the logger's clear input and waits out the logger's clearing sweep before accepting a new drain request.

## Interface
- AXI_ID_BITW, 8, logged ID width, in [1,24]; must match logger.
- TIMESTAMP_BITW, 32, logged timestamp width, in [1,32]; must match logger.
- NUM_LOG_ENTRIES, 16384, logger depth; capacity CAP = 1024*ceil_div(NUM_LOG_ENTRIES,1024).
- AXI_ADDR_BITW, 32, fixed.
- AXI_LEN_BITW, 8, fixed.
- Clk_CI  in  1  clock, single domain.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- Start_SI  in  1  drain request; sampled in IDLE only.
- Full_SI  in  1  logger Full output.
- Clear_SO  out  1  one-cycle clear pulse to logger.
- Busy_SO  out  1  high in every state except IDLE.
- EntryValid_SO  out  1  entry available.
- EntryReady_SI  in  1  consumer accepts entry.
- EntryTs_DO  out  TIMESTAMP_BITW  timestamp field.
- EntryAddr_DO  out  32  AXI address field.
- EntryLen_DO  out  8  AXI len field.
- EntryId_DO  out  AXI_ID_BITW  AXI ID field.
- EntryIdx_DO  out  log2(CAP)  entry index in log.
- Bram_PM  master  BramPort, DATA_WIDTH 32, ADDR_WIDTH 32  read port to logger; Clk_C = Clk_CI, Rst_R = ~Rst_RBI, Wr_D = 0, WrEn_S = 0 always.

## Operation
- States: IDLE, READ, OUT, CLEAR, WAIT.
- Entry e, word k (0..2) at byte address (3e+k)*4. Word 0 holds the timestamp in [TIMESTAMP_BITW-1:0]. Word 1 holds the address. Word 2 holds len in [7:0] and ID in [AXI_ID_BITW+7:8]; unused bits are ignored.
- IDLE: Start_SI=1 -> READ with idx=0.
- READ: issue 3 consecutive reads (En_S=1), then capture the 3 words into the entry register.
  - Terminal if idx>0 and all 3 words are zero (the logger clears memory to zero); terminal -> CLEAR, no output.
  - Otherwise -> OUT.
- OUT: EntryValid_SO=1 with all fields stable until EntryReady_SI=1.
  - On handshake: if idx==CAP-1 -> CLEAR; else idx+1, -> READ.
- CLEAR: Clear_SO=1 for exactly one cycle -> WAIT.
- WAIT: count CAP+2 cycles (reuses idx counter) -> IDLE. Start_SI is ignored.
- Start_SI while Busy_SO=1 is ignored. Full_SI carries no meaning without the macro.
- Entry 0 is always emitted, even if all zero.

## Timing
- Reset (async): state IDLE; all outputs 0; idx 0; entry register 0.
- BRAM read latency is 1 cycle: Rd_D is valid in the cycle after En_S/Addr_S.
- Start_SI high at cycle 0 -> word0/1/2 addresses at cycles 1/2/3 -> data at 2/3/4 -> EntryValid_SO at cycle 5.
- Handshake at cycle t -> next word-0 read at cycle t+1.
- No BRAM reads (En_S=0) in OUT, CLEAR, WAIT, IDLE.
- Terminal detection in READ at cycle 5 -> Clear_SO at cycle 6 -> WAIT from cycle 7 -> IDLE at cycle 7+CAP+2.
- Reset mid-operation: immediate IDLE, the in-flight entry is discarded, and no clear is issued.

## Configuration
- BRAM_LOG_READER_AUTO_DRAIN_EN
  - Defined: Full_SI=1 in IDLE starts a drain exactly like Start_SI.
  - Undefined: Full_SI is unused, and only Start_SI starts a drain.

## Structure
- Package bram_log_pkg holds:
  - entry layout constants: 96-bit entry, 3 words per entry, LEN_LOW=64, ID_LOW=72;
  - the state enum;
  - the CAP function;
  - a packed entry struct typedef shared with the logger.
- No sub-module; word assembly and the FSM are inline.

## Test plan
- Logger holding 3 entries (ts 5/9/12, addr 0x1000/0x2000/0x3000, len 3/0/7, id 1/2/3), Start pulse -> exactly 3 entries in order with those fields, idx 0..2, one Clear_SO pulse, Busy_SO low CAP+2 cycles after WAIT entry.
- Same log, EntryReady_SI held low 10 cycles on entry 1 -> fields unchanged, En_S=0 during the stall, entry 2 read starts the cycle after the handshake.
- NUM_LOG_ENTRIES=1024, all entries nonzero -> 1024 entries, last read address 12284, Clear_SO after idx 1023 handshake.
- All-zero memory, Start -> single all-zero entry idx 0 emitted, then Clear_SO.
- Macro defined, Full_SI=1 with no Start -> drain begins, EntryValid_SO at cycle 5. Macro undefined -> Busy_SO stays 0.
- Rst_RBI low during READ of entry 2 -> all outputs 0 asynchronously, no Clear_SO. After release, Start -> drain restarts at idx 0.
